// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: word size, reset/bubble constants, fetch FSM states.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  // IDLE: nothing outstanding; WAIT: response will be kept;
  // DROP: response will be discarded; HOLD: response parked in the buffer.
  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_WAIT = 2'd1,
    F_DROP = 2'd2,
    F_HOLD = 2'd3
  } fetch_state_e;

  // Instruction fetches are always word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register: bubble overrides load, otherwise contents hold.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            bubble,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instrD,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pc4D,
  output logic            validD
);

  // Register update: reset to bubble, bubble keeps the PC fields, load captures a new instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      instrD <= NOP_INSTR;
      pcD    <= '0;
      pc4D   <= '0;
      validD <= 1'b0;
    end else if (bubble) begin
      instrD <= NOP_INSTR;
      validD <= 1'b0;
    end else if (load) begin
      instrD <= instr;
      pcD    <= pc;
      pc4D   <= pc + 32'd4;
      validD <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch.sv
// RV32I instruction-fetch stage: PC register, one-outstanding-request imem port,
// a one-entry response buffer for decode stalls, and the IF/ID register.
module fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallF,
  input  logic            flushD,
  input  logic            pc_selE,
  input  logic [XLEN-1:0] pc_targetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instrD,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pc4D,
  output logic            validD,
  output logic            busyF
);

  // pc holds the address of the outstanding request (WAIT/DROP) or of the
  // next request to issue (IDLE/HOLD).
  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt, pc_plus4;
  logic [XLEN-1:0] buf_instr, buf_pc;
  logic            accept, capture, drain;
  logic [XLEN-1:0] ifid_instr, ifid_pc;

  assign pc_plus4 = pc + 32'd4;

  // A redirect or reset kills whatever the memory returns this cycle.
  assign accept  = !rst && !pc_selE && !stallF && (state == F_WAIT) && imem_rvalid;
  assign capture = !rst && !pc_selE &&  stallF && (state == F_WAIT) && imem_rvalid;
  assign drain   = !rst && !pc_selE && !stallF && (state == F_HOLD);

  // New request whenever idle, or back-to-back with a consumed instruction.
  assign imem_req  = !rst && !pc_selE && ((state == F_IDLE) || accept || drain);
  assign imem_addr = (state == F_WAIT) ? pc_plus4 : pc;
  assign busyF     = !(accept || drain);

  // Next fetch state and PC; redirect outranks every normal transition.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if (pc_selE) begin
      pc_nxt = word_align(pc_targetE);
      // Still owed a response only if one is outstanding and not arriving now.
      if (((state == F_WAIT) || (state == F_DROP)) && !imem_rvalid)
        state_nxt = F_DROP;
      else
        state_nxt = F_IDLE;
    end else begin
      case (state)
        F_IDLE: state_nxt = F_WAIT;
        F_WAIT: begin
          if (imem_rvalid) begin
            pc_nxt    = pc_plus4;
            state_nxt = stallF ? F_HOLD : F_WAIT;
          end
        end
        F_DROP: if (imem_rvalid) state_nxt = F_IDLE;
        F_HOLD: if (!stallF) state_nxt = F_WAIT;
        default: state_nxt = F_IDLE;
      endcase
    end
  end

  // Fetch state and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= F_IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // One-entry buffer for a response that arrives while decode is stalled;
  // it is considered full only while the FSM sits in HOLD.
  always_ff @(posedge clk) begin
    if (capture) begin
      buf_instr <= imem_rdata;
      buf_pc    <= pc;
    end
  end

  assign ifid_instr = drain ? buf_instr : imem_rdata;
  assign ifid_pc    = drain ? buf_pc    : pc;

  if_id_reg u_if_id (
    .clk    (clk),
    .rst    (rst),
    .load   (accept || drain),
    .bubble (pc_selE || flushD),
    .instr  (ifid_instr),
    .pc     (ifid_pc),
    .instrD (instrD),
    .pcD    (pcD),
    .pc4D   (pc4D),
    .validD (validD)
  );

endmodule
